// File: rtl/fft_iter_pkg.sv
// fft_iter_pkg: shared definitions for the iterative radix-2 FFT sequencer.
//   - FSM state encodings (legacy-compatible localparam constants)
//   - clog2 helper used to size counters and the LAYER port
package fft_iter_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RUN   = 3'd1;
  localparam logic [2:0] ST_GAP   = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Ceiling log2; returns 0 for inputs of 0 or 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_iter_ctrl_bf_addr_insert.sv
// bf_addr_insert: inserts a single bit into K at bit position P.
//   Bits of K below P stay in place, bits at or above P shift up by one.
// Ports:
//   K       in  AWL-1  butterfly index within the layer
//   P       in  PW     insertion position (0 .. AWL-1)
//   BIT_VAL in  1      value of the inserted bit
//   ADDR    out AWL    resulting memory address
module bf_addr_insert #(
  parameter int unsigned AWL = 5,
  parameter int unsigned PW  = 3
) (
  input  logic [AWL-2:0] K,
  input  logic [PW-1:0]  P,
  input  logic           BIT_VAL,
  output logic [AWL-1:0] ADDR
);

  logic [AWL-1:0] kx;
  logic [AWL-1:0] low_mask;

  always_comb begin
    kx       = {1'b0, K};
    low_mask = (AWL'(1) << P) - AWL'(1);
    ADDR     = ((kx & ~low_mask) << 1) | (kx & low_mask) | (AWL'(BIT_VAL) << P);
  end

endmodule

// File: rtl/fft_iter_ctrl.sv
// fft_iter_ctrl: sequencer for the iterative in-place radix-2 DIF FFT core.
//   Walks AWL layers of N/2 butterflies (N = 2^AWL), presenting operand
//   addresses A/B to the butterfly datapath and driving twiddle strobes.
// Build option: define FFT_CTRL_LAYER_GAP_EN to stall PIPE_LAT cycles between
//   layers (GAP state); otherwise layers run back to back.
// Parameters: AWL (address width, >= 2), PIPE_LAT (butterfly pipeline latency)
// Ports:
//   CLK       in   rising-edge clock
//   RST_N     in   asynchronous active-low reset
//   START     in   start request, sampled only in IDLE
//   READY     in   butterfly pipeline accepts the presented butterfly
//   BUSY      out  transform in progress (through the DONE cycle)
//   DONE      out  one-cycle completion pulse
//   BF_VALID  out  ADDR_A/ADDR_B/LAYER describe a butterfly
//   ADDR_A    out  upper-wing operand address
//   ADDR_B    out  lower-wing operand address
//   LAYER     out  current layer index
//   W_EN      out  twiddle step strobe (BF_VALID & READY)
//   W_LAY_EN  out  twiddle layer-advance strobe (last butterfly of a layer accepted)
module fft_iter_ctrl
  import fft_iter_pkg::*;
#(
  parameter int unsigned AWL      = 5,
  parameter int unsigned PIPE_LAT = 4
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    START,
  input  logic                    READY,
  output logic                    BUSY,
  output logic                    DONE,
  output logic                    BF_VALID,
  output logic [AWL-1:0]          ADDR_A,
  output logic [AWL-1:0]          ADDR_B,
  output logic [clog2(AWL)-1:0]   LAYER,
  output logic                    W_EN,
  output logic                    W_LAY_EN
);

  localparam int unsigned LW      = clog2(AWL);
  localparam int unsigned CW_RAW  = clog2(PIPE_LAT + 1);
  localparam int unsigned CW      = (CW_RAW > 0) ? CW_RAW : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((PIPE_LAT == 0) ? 0 : PIPE_LAT - 1);
  localparam logic [LW-1:0] S_LAST   = LW'(AWL - 1);
  localparam logic [LW-1:0] P_TOP    = LW'(AWL - 1);

  logic [2:0]     state_q, state_d;
  logic [AWL-2:0] k_q, k_d;
  logic [LW-1:0]  s_q, s_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic           run;
  logic           accept;
  logic           k_last;
  logic           s_last;
  logic [LW-1:0]  p;
  logic [AWL-1:0] addr_a_raw;
  logic [AWL-1:0] addr_b_raw;

  assign run    = (state_q == ST_RUN);
  assign accept = run & READY;
  assign k_last = (k_q == '1);
  assign s_last = (s_q == S_LAST);
  assign p      = P_TOP - s_q;

  bf_addr_insert #(.AWL(AWL), .PW(LW)) u_ins_a (
    .K       (k_q),
    .P       (p),
    .BIT_VAL (1'b0),
    .ADDR    (addr_a_raw)
  );

  bf_addr_insert #(.AWL(AWL), .PW(LW)) u_ins_b (
    .K       (k_q),
    .P       (p),
    .BIT_VAL (1'b1),
    .ADDR    (addr_b_raw)
  );

  // Addresses are forced to zero outside RUN so idle/reset outputs are all 0.
  assign BF_VALID = run;
  assign ADDR_A   = run ? addr_a_raw : '0;
  assign ADDR_B   = run ? addr_b_raw : '0;
  assign LAYER    = s_q;
  assign BUSY     = (state_q != ST_IDLE);
  assign DONE     = (state_q == ST_DONE);
  assign W_EN     = accept;
  assign W_LAY_EN = accept & k_last;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          k_d     = '0;
          s_d     = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (READY) begin
          if (k_last) begin
            k_d   = '0;
            cnt_d = '0;
            if (s_last) begin
              state_d = (PIPE_LAT == 0) ? ST_DONE : ST_DRAIN;
            end else begin
              s_d = s_q + 1'b1;
`ifdef FFT_CTRL_LAYER_GAP_EN
              state_d = (PIPE_LAT == 0) ? ST_RUN : ST_GAP;
`endif
            end
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
`ifdef FFT_CTRL_LAYER_GAP_EN
      ST_GAP: begin
        if (cnt_q == CNT_LAST) state_d = ST_RUN;
        else                   cnt_d   = cnt_q + 1'b1;
      end
`endif
      ST_DRAIN: begin
        if (cnt_q == CNT_LAST) state_d = ST_DONE;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fft_iter_ctrl.sv
// Testbench for fft_iter_ctrl with AWL=3, PIPE_LAT=2.
module tb_fft_iter_ctrl;

  localparam int unsigned AWL      = 3;
  localparam int unsigned PIPE_LAT = 2;
`ifdef FFT_CTRL_LAYER_GAP_EN
  localparam int BASE_DONE = 19;
`else
  localparam int BASE_DONE = 15;
`endif

  logic           CLK   = 1'b0;
  logic           RST_N = 1'b1;
  logic           START = 1'b0;
  logic           READY = 1'b0;
  logic           BUSY;
  logic           DONE;
  logic           BF_VALID;
  logic [AWL-1:0] ADDR_A;
  logic [AWL-1:0] ADDR_B;
  logic [1:0]     LAYER;
  logic           W_EN;
  logic           W_LAY_EN;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int a;
    int b;
    int lay;
    int lend;
  } bf_vec_t;

  bf_vec_t tbl[12];

  fft_iter_ctrl #(.AWL(AWL), .PIPE_LAT(PIPE_LAT)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .START    (START),
    .READY    (READY),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .BF_VALID (BF_VALID),
    .ADDR_A   (ADDR_A),
    .ADDR_B   (ADDR_B),
    .LAYER    (LAYER),
    .W_EN     (W_EN),
    .W_LAY_EN (W_LAY_EN)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},     int'(BUSY),     0);
    chk({tag, "_done"},     int'(DONE),     0);
    chk({tag, "_bf_valid"}, int'(BF_VALID), 0);
    chk({tag, "_addr_a"},   int'(ADDR_A),   0);
    chk({tag, "_addr_b"},   int'(ADDR_B),   0);
    chk({tag, "_layer"},    int'(LAYER),    0);
    chk({tag, "_w_en"},     int'(W_EN),     0);
    chk({tag, "_w_lay_en"}, int'(W_LAY_EN), 0);
  endtask

  // Caller raises START before the edge that accepts it (cycle 0).
  // READY drops for n_low cycles while butterfly index 5 (layer 1, 1/3) is presented.
  // START is pulsed again in cycle mid_start (0 = never).
  task automatic run_xfer(input int n_low, input int mid_start, input int exp_done);
    int  idx;
    int  low_used;
    int  wen_n;
    int  lay_n;
    int  c;
    bit  seen;
    idx = 0; low_used = 0; wen_n = 0; lay_n = 0; c = 1; seen = 1'b0;
    @(posedge CLK);
    while (!seen && c <= 80) begin
      #1;
      START = (c == mid_start);
      READY = !(idx == 5 && low_used < n_low);
      #1;
      chk("busy", int'(BUSY), 1);
      if (W_EN)     wen_n++;
      if (W_LAY_EN) lay_n++;
      if (BF_VALID) begin
        if (idx < 12) begin
          chk("addr_a", int'(ADDR_A), tbl[idx].a);
          chk("addr_b", int'(ADDR_B), tbl[idx].b);
          chk("layer",  int'(LAYER),  tbl[idx].lay);
          if (READY) begin
            chk("w_en", int'(W_EN), 1);
            chk("w_lay_en", int'(W_LAY_EN), tbl[idx].lend);
            idx++;
          end else begin
            chk("w_en_stall", int'(W_EN), 0);
            low_used++;
          end
        end else begin
          chk("extra_butterfly", idx, 11);
        end
      end else begin
        chk("w_en_idle", int'(W_EN), 0);
        chk("w_lay_en_idle", int'(W_LAY_EN), 0);
      end
      if (DONE) begin
        seen = 1'b1;
        chk("done_cycle", c, exp_done);
      end else begin
        @(posedge CLK);
        c++;
      end
    end
    chk("done_seen", int'(seen), 1);
    chk("bf_count", idx, 12);
    chk("w_en_count", wen_n, 12);
    chk("w_lay_en_count", lay_n, 3);
    chk("ready_low_used", low_used, n_low);
  endtask

  initial begin
    int w;
    tbl[0]  = '{0, 4, 0, 0};
    tbl[1]  = '{1, 5, 0, 0};
    tbl[2]  = '{2, 6, 0, 0};
    tbl[3]  = '{3, 7, 0, 1};
    tbl[4]  = '{0, 2, 1, 0};
    tbl[5]  = '{1, 3, 1, 0};
    tbl[6]  = '{4, 6, 1, 0};
    tbl[7]  = '{5, 7, 1, 1};
    tbl[8]  = '{0, 1, 2, 0};
    tbl[9]  = '{2, 3, 2, 0};
    tbl[10] = '{4, 5, 2, 0};
    tbl[11] = '{6, 7, 2, 1};

    // Reset state
    #2 RST_N = 1'b0;
    READY = 1'b1;
    #10;
    chk_all_zero("reset");
    @(negedge CLK);
    RST_N = 1'b1;

    // Full transform, READY held high
    @(negedge CLK);
    START = 1'b1;
    run_xfer(0, 0, BASE_DONE);
    @(posedge CLK);
    #2;
    chk("done_pulse_len", int'(DONE), 0);
    chk("busy_after_done", int'(BUSY), 0);

    // READY 1,0,0,1 during layer 1
    START = 1'b1;
    run_xfer(2, 0, BASE_DONE + 2);

    // START in the DONE cycle is ignored; START in the following IDLE cycle is taken
    START = 1'b1;
    @(posedge CLK);
    #2;
    chk("start_in_done_ignored_busy", int'(BUSY), 0);
    chk("start_in_done_ignored_valid", int'(BF_VALID), 0);
    // START pulsed again during RUN (cycle 3) must not disturb the transform
    run_xfer(0, 3, BASE_DONE);

    // Asynchronous reset mid layer 1
    @(posedge CLK);
    #2;
    START = 1'b1;
    READY = 1'b1;
    @(posedge CLK);
    #1 START = 1'b0;
    #1;
    w = 0;
    while (!(LAYER == 2'd1 && BF_VALID) && w < 20) begin
      @(posedge CLK);
      #2;
      w++;
    end
    chk("reached_layer1", int'(LAYER), 1);
    #1 RST_N = 1'b0;
    #1;
    chk_all_zero("async_reset");
    @(negedge CLK);
    RST_N = 1'b1;
    START = 1'b1;
    run_xfer(0, 0, BASE_DONE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_iter_ctrl.md
# fft_iter_ctrl

Sequencer for the iterative in-place radix-2 FFT core. It walks all AWL layers and all N/2 butterflies per layer, where N = 2^AWL. For each butterfly it emits the data-memory operand addresses A/B to the butterfly datapath. It also drives the step and layer-advance strobes consumed by the twiddle address generator. A START/BUSY/DONE handshake connects it to the system side, and a READY handshake connects it to the butterfly pipeline.

## Interface
- AWL, 5: data address width; N = 2^AWL points; AWL ≥ 2
- PIPE_LAT, 4: butterfly pipeline latency in cycles (read to write-back); 0 allowed
- CLK  in  1  rising-edge clock
- RST_N  in  1  asynchronous, active-low reset
- START  in  1  one-cycle request to run a full transform; sampled only in IDLE
- READY  in  1  butterfly pipeline accepts the presented butterfly this cycle
- BUSY  out  1  high from the cycle after START is accepted until DONE, inclusive
- DONE  out  1  one-cycle pulse when the transform is complete
- BF_VALID  out  1  ADDR_A/ADDR_B/LAYER describe a butterfly to issue
- ADDR_A  out  AWL  upper-wing (even) operand address
- ADDR_B  out  AWL  lower-wing operand address (ADDR_A + half-span)
- LAYER  out  clog2(AWL)  current layer index s, 0 first
- W_EN  out  1  twiddle step strobe, equal to BF_VALID & READY
- W_LAY_EN  out  1  twiddle layer-advance strobe; high on the cycle the last butterfly of a layer is accepted

## Operation
- States: IDLE, RUN, GAP, DRAIN, DONE.
- IDLE: START=1 clears k and s, then goes to RUN. START in any other state is ignored.
- RUN: BF_VALID=1. A butterfly is accepted when READY=1, which increments k.
  - If k = N/2−1 and s < AWL−1: s increments, k clears, and the FSM goes to GAP (or stays in RUN, see Configuration).
  - If k = N/2−1 and s = AWL−1: go to DRAIN.
- GAP: BF_VALID=0. Waits PIPE_LAT cycles so the previous layer's write-backs land before the next layer reads, then returns to RUN.
- DRAIN: BF_VALID=0. Waits PIPE_LAT cycles, then goes to DONE.
- DONE: DONE=1 for one cycle, then IDLE.
- Whenever a GAP or DRAIN is entered with PIPE_LAT=0, it is skipped.
- Address rule (decimation in frequency), with bit position p = AWL−1−s:
  - ADDR_A is k with a 0 inserted at bit p.
  - ADDR_B is k with a 1 inserted at bit p.
  - Half-span is 2^p. Concretely, bits below p come from k[p−1:0] and bits above p come from k[AWL−2:p].
- Width rules: k has AWL−1 bits, s has clog2(AWL) bits, and the gap/drain counter has clog2(PIPE_LAT+1) bits. No counter wraps mid-transform; k wraps to 0 only via the layer-end clear.
- READY low in RUN: ADDR_A, ADDR_B, LAYER and BF_VALID hold stable, and W_EN=0.
- W_LAY_EN is asserted only together with W_EN, at most AWL times per transform, including after the final layer.

## Timing
- Reset (asynchronous, any state): state=IDLE, k=0, s=0, and all outputs 0. This takes effect immediately, including mid-transform; no partial DONE is produced.
- All outputs are registered or decoded from registered state only. Nothing is combinational from START.
  - Exception: W_EN and W_LAY_EN are combinational from READY.
- Latency: START accepted at cycle 0 gives BUSY=1 and BF_VALID=1 with the first butterfly at cycle 1.
- Throughput: one butterfly per cycle while READY=1.
- Total cycles from START to DONE, with READY held high:
  - Gap compiled in: AWL·N/2 + AWL·PIPE_LAT + 1
  - Gap compiled out: AWL·N/2 + PIPE_LAT + 1
- START arriving in the DONE cycle is ignored. START is accepted again from IDLE on the following cycle.

## Configuration
- FFT_CTRL_LAYER_GAP_EN defined: the GAP state exists, and each layer boundary except the last stalls PIPE_LAT cycles.
- Macro undefined: the GAP state is not built. RUN continues directly into the next layer, and the memory side must handle read-after-write hazards. The final DRAIN is always present.

## Structure
- Shared package fft_iter_pkg holds:
  - the FSM state encoding localparams (IDLE, RUN, GAP, DRAIN, DONE);
  - the clog2 helper function.
- Sub-module bf_addr_insert: a combinational insertion of a single bit at a variable position. It takes k, p and the inserted bit value, and returns an AWL-bit address. It is instantiated twice, once for A and once for B.

## Test plan
- AWL=3, PIPE_LAT=2, READY=1, macro defined, START at cycle 0:
  - layer 0 issues A/B = 0/4, 1/5, 2/6, 3/7;
  - layer 1 issues 0/2, 1/3, 4/6, 5/7;
  - layer 2 issues 0/1, 2/3, 4/5, 6/7;
  - DONE at cycle 19.
- Same stimulus with the macro undefined: identical address sequence, no gaps, DONE at cycle 15.
- Check W_EN and W_LAY_EN counts over a transform:
  - W_EN asserted 12 times;
  - W_LAY_EN asserted exactly 3 times, on the cycles issuing 3/7, 5/7 and 6/7.
- READY toggling 1,0,0,1 during layer 1: addresses hold while READY=0, with no duplicated or skipped butterfly. DONE is delayed by exactly the number of READY-low cycles.
- START pulsed during RUN and again in the DONE cycle: both are ignored. START on the following IDLE cycle starts a new transform.
- RST_N asserted mid-layer-1 with no clock edge: all outputs go to 0 immediately. After release, START gives a fresh transform from ADDR_A=0, ADDR_B=4.
